// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared sizes, types and tag helpers for the reorder buffer
package reorder_buffer_pkg;
    localparam int ROB_SIZE     = 16;
    localparam int ROB_ID_WIDTH = 5;
    localparam int DATA_WIDTH   = 32;
    localparam int REG_WIDTH    = 5;
    localparam int PTR_WIDTH    = $clog2(ROB_SIZE);

    typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
    typedef logic [REG_WIDTH-1:0]    reg_pos_t;
    typedef logic [DATA_WIDTH-1:0]   data_t;
    typedef logic [PTR_WIDTH-1:0]    ptr_t;
    typedef logic [PTR_WIDTH:0]      count_t;

    localparam rob_id_t  INVALID_ROB = '0;
    localparam rob_id_t  MAX_TAG     = rob_id_t'(ROB_SIZE);
    localparam count_t   FULL_COUNT  = count_t'(ROB_SIZE);
    localparam reg_pos_t ZERO_REG    = '0;
    localparam logic     TRUE        = 1'b1;
    localparam logic     FALSE       = 1'b0;
    localparam data_t    NULL        = '0;

    typedef struct packed {
        logic     busy;
        logic     ready;
        reg_pos_t rd;
        logic     is_branch;
        logic     predicted;
        logic     jump;
        data_t    value;
        data_t    target;
    } rob_entry_t;

    // Tag = entry index + 1, so tag 0 can mean "no producer".
    function automatic ptr_t tag_to_idx(input rob_id_t tag);
        rob_id_t d;
        d = tag - 1'b1;
        return d[PTR_WIDTH-1:0];
    endfunction

    function automatic rob_id_t idx_to_tag(input ptr_t idx);
        return rob_id_t'(idx) + 1'b1;
    endfunction

    function automatic logic tag_valid(input rob_id_t tag);
        return tag != INVALID_ROB && tag <= MAX_TAG;
    endfunction
endpackage

// File: rtl/reorder_buffer_query_port.sv
// reorder_buffer_query_port: combinational operand tag lookup with CDB bypass
//   query_id       tag being looked up (0 = no producer, never ready)
//   busy / ready   per-entry state vectors
//   values         per-entry captured results
//   cdb_*          current broadcast, forwarded when it targets query_id
//   query_ready    operand available; query_value its value
module reorder_buffer_query_port
    import reorder_buffer_pkg::*;
(
    input  rob_id_t               query_id,
    input  logic [ROB_SIZE-1:0]   busy,
    input  logic [ROB_SIZE-1:0]   ready,
    input  data_t                 values [ROB_SIZE],
    input  logic                  cdb_valid,
    input  rob_id_t               cdb_id,
    input  data_t                 cdb_result,
    output logic                  query_ready,
    output data_t                 query_value
);
    ptr_t idx;
    logic live;
    logic fwd;
    always_comb begin
        idx         = tag_to_idx(query_id);
        live        = tag_valid(query_id) && busy[idx];
        fwd         = live && cdb_valid && cdb_id == query_id;
        query_ready = live && (ready[idx] || fwd);
        query_value = fwd ? cdb_result : values[idx];
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement with CDB capture, operand queries and branch rollback
//   dispatch : enable/rd/is_branch/predicted from cmd; rob_id_to_cmd = next tag, full_to_cmd
//   cdb      : valid/rob_id/result/jump/target_pc broadcast capture
//   query1/2 : combinational operand lookups with same-cycle CDB forwarding
//   commit   : commit_sign/V/Q/rd to the register block, one retire per cycle
//   rollback : rollback_sign + target_pc_to_if on a mispredicted retiring branch
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     enable_sign_from_cmd,
    input  reg_pos_t rd_from_cmd,
    input  logic     is_branch_from_cmd,
    input  logic     predicted_jump_from_cmd,
    output rob_id_t  rob_id_to_cmd,
    output logic     full_to_cmd,
    input  logic     valid_sign_from_cdb,
    input  rob_id_t  rob_id_from_cdb,
    input  data_t    result_from_cdb,
    input  logic     jump_from_cdb,
    input  data_t    target_pc_from_cdb,
    input  rob_id_t  query1_id_from_cmd,
    input  rob_id_t  query2_id_from_cmd,
    output logic     query1_ready_to_cmd,
    output logic     query2_ready_to_cmd,
    output data_t    query1_value_to_cmd,
    output data_t    query2_value_to_cmd,
    output logic     commit_sign_to_reg,
    output data_t    V_to_reg,
    output rob_id_t  Q_to_reg,
    output reg_pos_t rd_to_reg,
    output logic     rollback_sign,
    output data_t    target_pc_to_if
);
    rob_entry_t          entries [ROB_SIZE];
    ptr_t                head;
    ptr_t                tail;
    count_t              count;
    logic [ROB_SIZE-1:0] busy_vec;
    logic [ROB_SIZE-1:0] ready_vec;
    data_t               value_vec [ROB_SIZE];
    rob_entry_t          head_e;
    ptr_t                cdb_idx;
    logic                cdb_hit;
    logic                do_commit;
    logic                do_rollback;
    logic                do_dispatch;

    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_vec
        assign busy_vec[i]  = entries[i].busy;
        assign ready_vec[i] = entries[i].ready;
        assign value_vec[i] = entries[i].value;
    end

    // Dispatch is refused both in the cycle a rollback is decided and in the
    // following cycle while rollback_sign is still flushing the other units.
    always_comb begin
        head_e        = entries[head];
        do_commit     = head_e.busy && head_e.ready;
        do_rollback   = do_commit && head_e.is_branch && head_e.jump != head_e.predicted;
        full_to_cmd   = count == FULL_COUNT;
        do_dispatch   = enable_sign_from_cmd && !full_to_cmd && !rollback_sign && !do_rollback;
        cdb_idx       = tag_to_idx(rob_id_from_cdb);
        cdb_hit       = valid_sign_from_cdb && tag_valid(rob_id_from_cdb) && entries[cdb_idx].busy;
        rob_id_to_cmd = idx_to_tag(tail);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            commit_sign_to_reg <= FALSE;
            V_to_reg           <= NULL;
            Q_to_reg           <= INVALID_ROB;
            rd_to_reg          <= ZERO_REG;
            rollback_sign      <= FALSE;
            target_pc_to_if    <= NULL;
        end else begin
            commit_sign_to_reg <= do_commit;
            rollback_sign      <= do_rollback;
            target_pc_to_if    <= do_rollback ? head_e.target : NULL;
            if (do_commit) begin
                V_to_reg  <= head_e.value;
                Q_to_reg  <= idx_to_tag(head);
                rd_to_reg <= head_e.rd;
            end
            if (do_rollback) begin
                for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (cdb_hit) begin
                    entries[cdb_idx].value  <= result_from_cdb;
                    entries[cdb_idx].jump   <= jump_from_cdb;
                    entries[cdb_idx].target <= target_pc_from_cdb;
                    entries[cdb_idx].ready  <= TRUE;
                end
                // Later writes win: a retiring head is cleared after any late CDB write.
                if (do_commit) begin
                    entries[head] <= '0;
                    head          <= head + 1'b1;
                end
                if (do_dispatch) begin
                    entries[tail] <= '{busy: TRUE, ready: FALSE, rd: rd_from_cmd,
                                       is_branch: is_branch_from_cmd,
                                       predicted: predicted_jump_from_cmd,
                                       jump: FALSE, value: NULL, target: NULL};
                    tail          <= tail + 1'b1;
                end
                count <= count + count_t'(do_dispatch) - count_t'(do_commit);
            end
        end
    end

    reorder_buffer_query_port u_query1 (
        .query_id    (query1_id_from_cmd),
        .busy        (busy_vec),
        .ready       (ready_vec),
        .values      (value_vec),
        .cdb_valid   (valid_sign_from_cdb),
        .cdb_id      (rob_id_from_cdb),
        .cdb_result  (result_from_cdb),
        .query_ready (query1_ready_to_cmd),
        .query_value (query1_value_to_cmd)
    );

    reorder_buffer_query_port u_query2 (
        .query_id    (query2_id_from_cmd),
        .busy        (busy_vec),
        .ready       (ready_vec),
        .values      (value_vec),
        .cdb_valid   (valid_sign_from_cdb),
        .cdb_id      (rob_id_from_cdb),
        .cdb_result  (result_from_cdb),
        .query_ready (query2_ready_to_cmd),
        .query_value (query2_value_to_cmd)
    );
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
    logic        clk;
    logic        rst;
    logic        enable_sign_from_cmd;
    logic [4:0]  rd_from_cmd;
    logic        is_branch_from_cmd;
    logic        predicted_jump_from_cmd;
    logic [4:0]  rob_id_to_cmd;
    logic        full_to_cmd;
    logic        valid_sign_from_cdb;
    logic [4:0]  rob_id_from_cdb;
    logic [31:0] result_from_cdb;
    logic        jump_from_cdb;
    logic [31:0] target_pc_from_cdb;
    logic [4:0]  query1_id_from_cmd;
    logic [4:0]  query2_id_from_cmd;
    logic        query1_ready_to_cmd;
    logic        query2_ready_to_cmd;
    logic [31:0] query1_value_to_cmd;
    logic [31:0] query2_value_to_cmd;
    logic        commit_sign_to_reg;
    logic [31:0] V_to_reg;
    logic [4:0]  Q_to_reg;
    logic [4:0]  rd_to_reg;
    logic        rollback_sign;
    logic [31:0] target_pc_to_if;

    int passed = 0;
    int total  = 0;

    reorder_buffer dut (
        .clk                     (clk),
        .rst                     (rst),
        .enable_sign_from_cmd    (enable_sign_from_cmd),
        .rd_from_cmd             (rd_from_cmd),
        .is_branch_from_cmd      (is_branch_from_cmd),
        .predicted_jump_from_cmd (predicted_jump_from_cmd),
        .rob_id_to_cmd           (rob_id_to_cmd),
        .full_to_cmd             (full_to_cmd),
        .valid_sign_from_cdb     (valid_sign_from_cdb),
        .rob_id_from_cdb         (rob_id_from_cdb),
        .result_from_cdb         (result_from_cdb),
        .jump_from_cdb           (jump_from_cdb),
        .target_pc_from_cdb      (target_pc_from_cdb),
        .query1_id_from_cmd      (query1_id_from_cmd),
        .query2_id_from_cmd      (query2_id_from_cmd),
        .query1_ready_to_cmd     (query1_ready_to_cmd),
        .query2_ready_to_cmd     (query2_ready_to_cmd),
        .query1_value_to_cmd     (query1_value_to_cmd),
        .query2_value_to_cmd     (query2_value_to_cmd),
        .commit_sign_to_reg      (commit_sign_to_reg),
        .V_to_reg                (V_to_reg),
        .Q_to_reg                (Q_to_reg),
        .rd_to_reg               (rd_to_reg),
        .rollback_sign           (rollback_sign),
        .target_pc_to_if         (target_pc_to_if)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable_sign_from_cmd    = 0;
        rd_from_cmd             = 0;
        is_branch_from_cmd      = 0;
        predicted_jump_from_cmd = 0;
        valid_sign_from_cdb     = 0;
        rob_id_from_cdb         = 0;
        result_from_cdb         = 0;
        jump_from_cdb           = 0;
        target_pc_from_cdb      = 0;
        query1_id_from_cmd      = 0;
        query2_id_from_cmd      = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic br, input logic pred);
        enable_sign_from_cmd    = 1;
        rd_from_cmd             = rd;
        is_branch_from_cmd      = br;
        predicted_jump_from_cmd = pred;
        tick();
        enable_sign_from_cmd    = 0;
        is_branch_from_cmd      = 0;
        predicted_jump_from_cmd = 0;
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] val, input logic j, input logic [31:0] tgt);
        valid_sign_from_cdb = 1;
        rob_id_from_cdb     = id;
        result_from_cdb     = val;
        jump_from_cdb       = j;
        target_pc_from_cdb  = tgt;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL reset_commit: got %b expected 0", commit_sign_to_reg); else passed++;
        total++; if (rollback_sign !== 1'b0) $display("FAIL reset_rollback: got %b expected 0", rollback_sign); else passed++;
        total++; if (rob_id_to_cmd !== 5'd1) $display("FAIL reset_rob_id: got %0d expected 1", rob_id_to_cmd); else passed++;
        total++; if (full_to_cmd !== 1'b0) $display("FAIL reset_full: got %b expected 0", full_to_cmd); else passed++;
        total++; if ({V_to_reg, Q_to_reg, rd_to_reg, target_pc_to_if} !== '0) $display("FAIL reset_outputs: got V=%h Q=%0d rd=%0d pc=%h expected all 0", V_to_reg, Q_to_reg, rd_to_reg, target_pc_to_if); else passed++;
    endtask

    task automatic test_commit_basic();
        do_reset();
        dispatch(5'd5, 0, 0);
        total++; if (rob_id_to_cmd !== 5'd2) $display("FAIL basic_next_tag: got %0d expected 2", rob_id_to_cmd); else passed++;
        cdb(5'd1, 32'h2A, 0, 0);
        tick();
        valid_sign_from_cdb = 0;
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL basic_early_commit: got %b expected 0", commit_sign_to_reg); else passed++;
        tick();
        total++; if (commit_sign_to_reg !== 1'b1) $display("FAIL basic_commit: got %b expected 1", commit_sign_to_reg); else passed++;
        total++; if (rd_to_reg !== 5'd5) $display("FAIL basic_rd: got %0d expected 5", rd_to_reg); else passed++;
        total++; if (V_to_reg !== 32'h2A) $display("FAIL basic_V: got %h expected 0000002a", V_to_reg); else passed++;
        total++; if (Q_to_reg !== 5'd1) $display("FAIL basic_Q: got %0d expected 1", Q_to_reg); else passed++;
        total++; if (rollback_sign !== 1'b0) $display("FAIL basic_rollback: got %b expected 0", rollback_sign); else passed++;
        tick();
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL basic_single_pulse: got %b expected 0", commit_sign_to_reg); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) dispatch(5'(i + 1), 0, 0);
        total++; if (full_to_cmd !== 1'b1) $display("FAIL full_flag: got %b expected 1", full_to_cmd); else passed++;
        total++; if (rob_id_to_cmd !== 5'd1) $display("FAIL full_wrap_tag: got %0d expected 1", rob_id_to_cmd); else passed++;
        dispatch(5'd20, 0, 0);
        total++; if (rob_id_to_cmd !== 5'd1) $display("FAIL full_17th_tag: got %0d expected 1", rob_id_to_cmd); else passed++;
        total++; if (full_to_cmd !== 1'b1) $display("FAIL full_17th_flag: got %b expected 1", full_to_cmd); else passed++;
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL full_no_commit: got %b expected 0", commit_sign_to_reg); else passed++;
        // Full buffer committing its head still refuses a dispatch in that cycle.
        cdb(5'd1, 32'h11, 0, 0);
        tick();
        valid_sign_from_cdb  = 0;
        enable_sign_from_cmd = 1;
        rd_from_cmd          = 5'd9;
        tick();
        enable_sign_from_cmd = 0;
        total++; if (commit_sign_to_reg !== 1'b1 || Q_to_reg !== 5'd1) $display("FAIL full_commit: got commit=%b Q=%0d expected 1/1", commit_sign_to_reg, Q_to_reg); else passed++;
        total++; if (rob_id_to_cmd !== 5'd1 || full_to_cmd !== 1'b0) $display("FAIL full_refuse_during_commit: got tag=%0d full=%b expected 1/0", rob_id_to_cmd, full_to_cmd); else passed++;
    endtask

    task automatic test_in_order();
        logic [4:0]  exp_q [3] = '{5'd1, 5'd2, 5'd3};
        logic [31:0] exp_v [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int i = 0; i < 3; i++) dispatch(5'(i + 10), 0, 0);
        for (int i = 2; i >= 0; i--) begin
            cdb(exp_q[i], exp_v[i], 0, 0);
            tick();
            total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL order_premature_%0d: got %b expected 0", i, commit_sign_to_reg); else passed++;
        end
        valid_sign_from_cdb = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (commit_sign_to_reg !== 1'b1 || Q_to_reg !== exp_q[i] || V_to_reg !== exp_v[i] || rd_to_reg !== 5'(i + 10))
                $display("FAIL order_commit_%0d: got c=%b Q=%0d V=%h rd=%0d expected 1/%0d/%h/%0d", i, commit_sign_to_reg, Q_to_reg, V_to_reg, rd_to_reg, exp_q[i], exp_v[i], i + 10);
            else passed++;
        end
        tick();
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL order_drain: got %b expected 0", commit_sign_to_reg); else passed++;
    endtask

    task automatic test_rollback();
        do_reset();
        dispatch(5'd0, 1, 0);
        dispatch(5'd7, 0, 0);
        dispatch(5'd8, 0, 0);
        dispatch(5'd9, 0, 0);
        cdb(5'd1, 32'h0, 1, 32'h100);
        tick();
        // These arrive in the rollback cycle and must be discarded.
        cdb(5'd2, 32'h5, 0, 0);
        enable_sign_from_cmd = 1;
        rd_from_cmd          = 5'd3;
        tick();
        idle();
        total++; if (rollback_sign !== 1'b1) $display("FAIL rb_sign: got %b expected 1", rollback_sign); else passed++;
        total++; if (target_pc_to_if !== 32'h100) $display("FAIL rb_target: got %h expected 00000100", target_pc_to_if); else passed++;
        total++; if (commit_sign_to_reg !== 1'b1 || Q_to_reg !== 5'd1) $display("FAIL rb_commit: got c=%b Q=%0d expected 1/1", commit_sign_to_reg, Q_to_reg); else passed++;
        total++; if (full_to_cmd !== 1'b0 || rob_id_to_cmd !== 5'd1) $display("FAIL rb_flush: got full=%b tag=%0d expected 0/1", full_to_cmd, rob_id_to_cmd); else passed++;
        tick();
        total++; if (rollback_sign !== 1'b0 || commit_sign_to_reg !== 1'b0) $display("FAIL rb_after: got rb=%b c=%b expected 0/0", rollback_sign, commit_sign_to_reg); else passed++;
        total++; if (rob_id_to_cmd !== 5'd1) $display("FAIL rb_after_tag: got %0d expected 1", rob_id_to_cmd); else passed++;
        tick();
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL rb_stale_commit: got %b expected 0", commit_sign_to_reg); else passed++;
    endtask

    task automatic test_branch_correct();
        do_reset();
        dispatch(5'd4, 1, 1);
        cdb(5'd1, 32'h77, 1, 32'h200);
        tick();
        valid_sign_from_cdb = 0;
        tick();
        total++; if (commit_sign_to_reg !== 1'b1 || rollback_sign !== 1'b0) $display("FAIL br_ok: got c=%b rb=%b expected 1/0", commit_sign_to_reg, rollback_sign); else passed++;
        total++; if (rob_id_to_cmd !== 5'd2) $display("FAIL br_ok_tag: got %0d expected 2", rob_id_to_cmd); else passed++;
    endtask

    task automatic test_query();
        do_reset();
        dispatch(5'd1, 0, 0);
        dispatch(5'd2, 0, 0);
        query1_id_from_cmd = 5'd2;
        query2_id_from_cmd = 5'd1;
        #1;
        total++; if (query1_ready_to_cmd !== 1'b0 || query2_ready_to_cmd !== 1'b0) $display("FAIL q_pending: got %b/%b expected 0/0", query1_ready_to_cmd, query2_ready_to_cmd); else passed++;
        cdb(5'd2, 32'h7, 0, 0);
        #1;
        total++; if (query1_ready_to_cmd !== 1'b1 || query1_value_to_cmd !== 32'h7) $display("FAIL q_forward: got r=%b v=%h expected 1/00000007", query1_ready_to_cmd, query1_value_to_cmd); else passed++;
        total++; if (query2_ready_to_cmd !== 1'b0) $display("FAIL q_other_tag: got %b expected 0", query2_ready_to_cmd); else passed++;
        tick();
        valid_sign_from_cdb = 0;
        #1;
        total++; if (query1_ready_to_cmd !== 1'b1 || query1_value_to_cmd !== 32'h7) $display("FAIL q_stored: got r=%b v=%h expected 1/00000007", query1_ready_to_cmd, query1_value_to_cmd); else passed++;
        query2_id_from_cmd = 5'd0;
        cdb(5'd0, 32'h9, 0, 0);
        #1;
        total++; if (query2_ready_to_cmd !== 1'b0) $display("FAIL q_tag0: got %b expected 0", query2_ready_to_cmd); else passed++;
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 0, 0);
        cdb(5'd1, 32'hAB, 0, 0);
        tick();
        valid_sign_from_cdb = 0;
        rst = 1;
        tick();
        rst = 0;
        total++; if (commit_sign_to_reg !== 1'b0 || rollback_sign !== 1'b0) $display("FAIL rst_mid_pulses: got c=%b rb=%b expected 0/0", commit_sign_to_reg, rollback_sign); else passed++;
        total++; if (rob_id_to_cmd !== 5'd1 || full_to_cmd !== 1'b0) $display("FAIL rst_mid_state: got tag=%0d full=%b expected 1/0", rob_id_to_cmd, full_to_cmd); else passed++;
        tick();
        total++; if (commit_sign_to_reg !== 1'b0) $display("FAIL rst_mid_no_commit: got %b expected 0", commit_sign_to_reg); else passed++;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_commit_basic();
        test_full();
        test_in_order();
        test_rollback();
        test_branch_correct();
        test_query();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
